// File: rtl/mod_n_pkg.sv
// ============================================================================
// Module : mod_n_pkg
// Brief  : Shared constants, duty-shadow state type and duty clamp helper
//          for the mod-N PWM generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mod_n_pkg;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int DW = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // Saturate a requested duty at the modulus (100% high).
    function automatic int clamp_duty(input int duty, input int n);
        return (duty > n) ? n : duty;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_n_duty_shadow.sv
// ============================================================================
// Module : mod_n_duty_shadow
// Brief  : Double-buffered duty register; writes are held pending and become
//          active only on the period boundary cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_n_duty_shadow
    import mod_n_pkg::*;
#(
    parameter int N  = mod_n_pkg::N,
    parameter int DW = mod_n_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bnd_i,
    input  logic [DW-1:0] duty_i,
    input  logic          wr_i,
    output logic [DW-1:0] duty_act_o,
    output logic          pending_o,
    output logic          wr_ack_o
);

    state_t        state_q;
    logic [DW-1:0] duty_pend_q;
    logic [DW-1:0] duty_act_q;
    logic          wr_ack_q;
    logic [DW-1:0] duty_clamp;

    assign duty_clamp = DW'(clamp_duty(32'(duty_i), N));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            duty_pend_q <= '0;
            duty_act_q  <= '0;
            wr_ack_q    <= 1'b0;
        end else begin
            wr_ack_q <= wr_i;
            case (state_q)
                IDLE: begin
                    // A write landing on the boundary bypasses the shadow.
                    if (wr_i && bnd_i) begin
                        duty_act_q <= duty_clamp;
                    end else if (wr_i) begin
                        duty_pend_q <= duty_clamp;
                        state_q     <= PEND;
                    end
                end
                PEND: begin
                    if (bnd_i) begin
                        duty_act_q <= wr_i ? duty_clamp : duty_pend_q;
                        state_q    <= IDLE;
                    end else if (wr_i) begin
                        duty_pend_q <= duty_clamp;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign duty_act_o = duty_act_q;
    assign pending_o  = (state_q == PEND);
    assign wr_ack_o   = wr_ack_q;

endmodule

`default_nettype wire

// File: rtl/mod_n_pwm_gen.sv
// ============================================================================
// Module : mod_n_pwm_gen
// Brief  : PWM generator driven by an external mod-N count, with glitch-free
//          double-buffered duty, period tick and sticky range error.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mod_n_pwm_gen
    import mod_n_pkg::*;
#(
    parameter int N  = mod_n_pkg::N,
    parameter int W  = mod_n_pkg::W,
    parameter int DW = mod_n_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cnt_en,
    input  logic [W-1:0]  cnt,
    input  logic [DW-1:0] duty_in,
    input  logic          duty_wr,
    output logic          wr_ack,
    output logic          pending,
    output logic          pwm_out,
    output logic          period_tick,
    output logic          range_err
);

    logic          bnd;
    logic          in_range;
    logic          pwm_d;
    logic [DW-1:0] duty_act;
    logic          pwm_q;
    logic          tick_q;
    logic          rerr_q;

    assign in_range = (32'(cnt) < N);
    assign bnd      = cnt_en && (32'(cnt) == N - 1);
    // duty_act here is still the pre-boundary value, so a new duty starts at count 0.
    assign pwm_d    = in_range && (32'(cnt) < 32'(duty_act));

    mod_n_duty_shadow #(
        .N  (N),
        .DW (DW)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .bnd_i      (bnd),
        .duty_i     (duty_in),
        .wr_i       (duty_wr),
        .duty_act_o (duty_act),
        .pending_o  (pending),
        .wr_ack_o   (wr_ack)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_q  <= 1'b0;
            tick_q <= 1'b0;
            rerr_q <= 1'b0;
        end else begin
            tick_q <= bnd;
            if (cnt_en) begin
                pwm_q <= pwm_d;
                if (!in_range) begin
                    rerr_q <= 1'b1;
                end
            end
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign range_err   = rerr_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_n_pwm_gen.sv
// ============================================================================
// Module : tb_mod_n_pwm_gen
// Brief  : Directed self-checking bench for mod_n_pwm_gen (N=4 and N=3 builds).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mod_n_pwm_gen;

    logic       clk;
    logic       rst;

    logic       cnt_en;
    logic [1:0] cnt;
    logic [2:0] duty_in;
    logic       duty_wr;
    logic       wr_ack, pending, pwm_out, period_tick, range_err;

    logic       cnt_en3;
    logic [1:0] cnt3;
    logic [2:0] duty_in3;
    logic       duty_wr3;
    logic       wr_ack3, pending3, pwm_out3, period_tick3, range_err3;

    int n_chk  = 0;
    int n_fail = 0;

    mod_n_pwm_gen #(.N(4), .W(2), .DW(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_en      (cnt_en),
        .cnt         (cnt),
        .duty_in     (duty_in),
        .duty_wr     (duty_wr),
        .wr_ack      (wr_ack),
        .pending     (pending),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .range_err   (range_err)
    );

    mod_n_pwm_gen #(.N(3), .W(2), .DW(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .cnt_en      (cnt_en3),
        .cnt         (cnt3),
        .duty_in     (duty_in3),
        .duty_wr     (duty_wr3),
        .wr_ack      (wr_ack3),
        .pending     (pending3),
        .pwm_out     (pwm_out3),
        .period_tick (period_tick3),
        .range_err   (range_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic [1:0] c, input logic [2:0] d, input logic wr);
        cnt_en  = en;
        cnt     = c;
        duty_in = d;
        duty_wr = wr;
        @(posedge clk);
        #1;
        duty_wr = 1'b0;
    endtask

    task automatic cyc3(input logic en, input logic [1:0] c, input logic [2:0] d, input logic wr);
        cnt_en   = 1'b0;
        duty_wr  = 1'b0;
        cnt_en3  = en;
        cnt3     = c;
        duty_in3 = d;
        duty_wr3 = wr;
        @(posedge clk);
        #1;
        duty_wr3 = 1'b0;
    endtask

    // One full enabled period 0..3; optional writes at counts wa/wb.
    task automatic period(input string tag, input logic [3:0] exp_pwm, input logic [3:0] exp_pend,
                          input int wa, input logic [2:0] da, input int wb, input logic [2:0] db);
        for (int i = 0; i < 4; i++) begin
            if (i == wa)      cyc(1'b1, 2'(i), da, 1'b1);
            else if (i == wb) cyc(1'b1, 2'(i), db, 1'b1);
            else              cyc(1'b1, 2'(i), 3'd0, 1'b0);
            chk($sformatf("%s_pwm%0d", tag, i),  32'(pwm_out),     32'(exp_pwm[i]));
            chk($sformatf("%s_tick%0d", tag, i), 32'(period_tick), (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("%s_pend%0d", tag, i), 32'(pending),     32'(exp_pend[i]));
            chk($sformatf("%s_ack%0d", tag, i),  32'(wr_ack),      (i == wa || i == wb) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        cnt_en = 1'b0; cnt = '0; duty_in = '0; duty_wr = 1'b0;
        cnt_en3 = 1'b0; cnt3 = '0; duty_in3 = '0; duty_wr3 = 1'b0;

        #12;
        chk("rst_pwm",  32'(pwm_out),     32'd0);
        chk("rst_tick", 32'(period_tick), 32'd0);
        chk("rst_ack",  32'(wr_ack),      32'd0);
        chk("rst_pend", 32'(pending),     32'd0);
        chk("rst_rerr", 32'(range_err),   32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Write 2 mid-period: held pending, applied next period
        period("t1a", 4'b0000, 4'b0110, 1, 3'd2, -1, 3'd0);
        period("t1b", 4'b0011, 4'b0000, -1, 3'd0, -1, 3'd0);

        // Write 3 on the boundary: direct update, never pending
        period("t2a", 4'b0011, 4'b0000, 3, 3'd3, -1, 3'd0);
        period("t2b", 4'b0111, 4'b0000, -1, 3'd0, -1, 3'd0);

        // Clamp 7 -> 4 (always high), then 0 (always low)
        period("t4a", 4'b0111, 4'b0000, 3, 3'd7, -1, 3'd0);
        period("t4b", 4'b1111, 4'b0000, -1, 3'd0, -1, 3'd0);
        period("t4c", 4'b1111, 4'b0000, 3, 3'd0, -1, 3'd0);
        period("t4d", 4'b0000, 4'b0000, -1, 3'd0, -1, 3'd0);

        // Two writes in one period: newest wins
        period("t3a", 4'b0000, 4'b0111, 0, 3'd1, 1, 3'd3);
        period("t3b", 4'b0111, 4'b0000, -1, 3'd0, -1, 3'd0);

        // Freeze mid-period; a write while frozen still goes pending
        cyc(1'b1, 2'd0, 3'd0, 1'b0);
        chk("t5_pwm0", 32'(pwm_out), 32'd1);
        cyc(1'b1, 2'd1, 3'd0, 1'b0);
        chk("t5_pwm1", 32'(pwm_out), 32'd1);
        cyc(1'b0, 2'd3, 3'd1, 1'b1);
        chk("t5_frz_pwm0",  32'(pwm_out),     32'd1);
        chk("t5_frz_tick0", 32'(period_tick), 32'd0);
        chk("t5_frz_pend0", 32'(pending),     32'd1);
        chk("t5_frz_ack0",  32'(wr_ack),      32'd1);
        for (int k = 1; k < 3; k++) begin
            cyc(1'b0, 2'd3, 3'd0, 1'b0);
            chk($sformatf("t5_frz_pwm%0d", k),  32'(pwm_out),     32'd1);
            chk($sformatf("t5_frz_tick%0d", k), 32'(period_tick), 32'd0);
            chk($sformatf("t5_frz_pend%0d", k), 32'(pending),     32'd1);
        end
        cyc(1'b1, 2'd2, 3'd0, 1'b0);
        chk("t5_pwm2", 32'(pwm_out), 32'd1);
        cyc(1'b1, 2'd3, 3'd0, 1'b0);
        chk("t5_pwm3",  32'(pwm_out),     32'd0);
        chk("t5_tick3", 32'(period_tick), 32'd1);
        chk("t5_pend3", 32'(pending),     32'd0);
        period("t5b", 4'b0001, 4'b0000, -1, 3'd0, -1, 3'd0);

        // N=3 build: 100% duty, then out-of-range count
        cyc3(1'b1, 2'd0, 3'd0, 1'b0);
        cyc3(1'b1, 2'd1, 3'd0, 1'b0);
        cyc3(1'b1, 2'd2, 3'd3, 1'b1);
        chk("t6_tick_b",  32'(period_tick3), 32'd1);
        chk("t6_pend_b",  32'(pending3),     32'd0);
        cyc3(1'b1, 2'd0, 3'd0, 1'b0);
        chk("t6_pwm_c0",  32'(pwm_out3),     32'd1);
        chk("t6_rerr_c0", 32'(range_err3),   32'd0);
        cyc3(1'b1, 2'd3, 3'd0, 1'b0);
        chk("t6_pwm_oor",  32'(pwm_out3),     32'd0);
        chk("t6_rerr_oor", 32'(range_err3),   32'd1);
        chk("t6_tick_oor", 32'(period_tick3), 32'd0);
        cyc3(1'b1, 2'd0, 3'd0, 1'b0);
        chk("t6_pwm_after",  32'(pwm_out3),   32'd1);
        chk("t6_rerr_stick", 32'(range_err3), 32'd1);
        cyc3(1'b0, 2'd0, 3'd0, 1'b0);
        chk("t6_rerr_hold", 32'(range_err3), 32'd1);

        // Reset mid-period with a pending write
        cyc(1'b1, 2'd0, 3'd2, 1'b1);
        chk("t7_pre_pwm",  32'(pwm_out), 32'd1);
        chk("t7_pre_pend", 32'(pending), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t7_rst_pwm",   32'(pwm_out),    32'd0);
        chk("t7_rst_pend",  32'(pending),    32'd0);
        chk("t7_rst_ack",   32'(wr_ack),     32'd0);
        chk("t7_rst_rerr3", 32'(range_err3), 32'd0);
        chk("t7_rst_pwm3",  32'(pwm_out3),   32'd0);
        @(negedge clk);
        rst = 1'b1;
        period("t7a", 4'b0000, 4'b0000, -1, 3'd0, -1, 3'd0);
        period("t7b", 4'b0000, 4'b0000, -1, 3'd0, -1, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
